// File: rtl/motor_arbiter.sv
// motor_arbiter: frame-synchronous fixed-priority motor arbiter with brake gap and owner watchdog
//   clk, reset                        clock, async active-high reset
//   req[2:0]                          requests: 0 line follower, 1 turn, 2 station
//   ml/mr_rst_in, ml/mr_dir_in [2:0]  per-requester motor commands, indexed as req
//   clear_err                         sync clear of timeout_err
//   grant[2:0]                        one-hot owner or 000
//   frame_start                       high while frame counter is 0
//   motor_{l,r}_{reset,direction}     registered muxed motor commands
//   timeout_err                       sticky watchdog flag
module motor_arbiter #(
  parameter int PERIOD     = 2_000_000,
  parameter int MAX_FRAMES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] ml_rst_in,
  input  logic [2:0] ml_dir_in,
  input  logic [2:0] mr_rst_in,
  input  logic [2:0] mr_dir_in,
  input  logic       clear_err,
  output logic [2:0] grant,
  output logic       frame_start,
  output logic       motor_l_reset,
  output logic       motor_l_direction,
  output logic       motor_r_reset,
  output logic       motor_r_direction,
  output logic       timeout_err
);
  localparam int FW = $clog2(PERIOD);
  localparam int OW = $clog2(MAX_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
  state_t state;
  logic [FW-1:0] fcnt;
  logic [OW-1:0] ofc, ofc_inc;
  logic [2:0] mask, elig, pick, higher;
  logic bnd, wd, expire, leave;
  assign frame_start = fcnt == '0;
  always_comb begin
    bnd = fcnt == FW'(PERIOD - 1);
    elig = req & ~mask;
    pick = elig[2] ? 3'b100 : elig[1] ? 3'b010 : elig[0] ? 3'b001 : 3'b000;
    higher = {grant[1] | grant[0], grant[0], 1'b0};
    wd = grant[2] | grant[1];
    ofc_inc = ofc + OW'(1);
    expire = bnd && state == OWN && wd && ofc_inc == OW'(MAX_FRAMES);
    leave = bnd && state == OWN && (~|(req & grant) || |(elig & higher) || expire);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      fcnt <= '0;
      ofc <= '0;
      mask <= '0;
      timeout_err <= 1'b0;
      {motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction} <= 4'b1010;
    end else begin
      fcnt <= bnd ? '0 : fcnt + FW'(1);
      timeout_err <= expire | (timeout_err & ~clear_err);
      // Outputs switch to brake on the leaving edge so the GAP frame starts braked.
      {motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction} <=
        (state == OWN && !leave) ? {|(ml_rst_in & grant), |(ml_dir_in & grant),
                                    |(mr_rst_in & grant), |(mr_dir_in & grant)} : 4'b1010;
      if (bnd) begin
        mask <= ((mask & req) | (expire ? grant : 3'b000)) & 3'b110;
        if (state != OWN) begin
          state <= |pick ? OWN : IDLE;
          grant <= pick;
          ofc <= '0;
        end else if (leave) begin
          state <= GAP;
          grant <= '0;
        end else if (wd) begin
          ofc <= ofc_inc;
        end
      end
    end
  end
endmodule
